alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the CPU's combinational calc function. It executes the eight existing ALU ops plus unsigned multiply, multiply-high, divide and remainder behind a valid/ready handshake. Single-cycle ops complete in one cycle; mul/div iterate one bit per cycle. It sits between the decode and writeback stages and stalls issue through `in_ready`.

---
 rtl/alu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned
// mul/mulhu/divu/remu (one bit per cycle) behind a valid/ready handshake.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a new op; simple ops and div-by-zero finish here
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | result held on out_data/out_tag until out_ready
module alu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_opt,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [4:0]      in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_tag,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state_q, state_d;

  logic              hi_sel_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc_q;
  logic [SHW-1:0]    cnt_q;

  logic              is_mul, is_div, b_zero, last;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   simple_res;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

  assign is_mul = (in_opt[3:1] == 3'b100);
  assign is_div = (in_opt[3:1] == 3'b101);
  assign b_zero = (in_b == '0);
  assign last   = (cnt_q == '0);
  assign shamt  = in_b[SHW-1:0];

  always_comb begin
    simple_res = '0;
    case (in_opt)
      4'h0:    simple_res = in_a + in_b;
      4'h1:    simple_res = in_a - in_b;
      4'h2:    simple_res = in_a << shamt;
      4'h3:    simple_res = $signed(in_a) >>> shamt;
      4'h4:    simple_res = in_a >> shamt;
      4'h5:    simple_res = in_a & in_b;
      4'h6:    simple_res = in_a | in_b;
      4'h7:    simple_res = in_a ^ in_b;
      default: simple_res = '0;
    endcase
  end

  // acc holds {partial product, remaining multiplier} for MUL
  // and {partial remainder, dividend/quotient} for DIV.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_mul)                  state_d = MUL;
          else if (is_div && !b_zero)  state_d = DIV;
          else                         state_d = DONE;
        end
      end
      MUL, DIV: if (last) state_d = DONE;
      DONE:     if (out_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_sel_q  <= 1'b0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            hi_sel_q <= in_opt[0];
            b_q      <= in_b;
            acc_q    <= {{XLEN{1'b0}}, in_a};
            cnt_q    <= SHW'(XLEN - 1);
            out_tag  <= in_tag;
            if (!(is_mul || (is_div && !b_zero))) begin
              out_valid <= 1'b1;
              out_data  <= is_div ? (in_opt[0] ? in_a : '1) : simple_res;
            end
          end
        end
        MUL: begin
          acc_q <= mul_next;
          if (last) begin
            out_valid <= 1'b1;
            out_data  <= hi_sel_q ? mul_next[2*XLEN-1:XLEN] : mul_next[XLEN-1:0];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DIV: begin
          acc_q <= div_next;
          if (last) begin
            out_valid <= 1'b1;
            out_data  <= hi_sel_q ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE:    if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors at XLEN=32, plus random
// sweeps at XLEN=8 and XLEN=64 checked against a behavioural model.
module tb_alu_seq;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int w, input logic [3:0] op, input logic [63:0] b);
    if (op == 4'h8 || op == 4'h9) return w + 1;
    if ((op == 4'hA || op == 4'hB) && b != 0) return w + 1;
    return 1;
  endfunction

  function automatic logic [63:0] refm(input int w, input logic [3:0] op,
                                       input logic [63:0] a, input logic [63:0] b);
    logic [63:0]  m, r, sa;
    logic [127:0] p;
    int           sh;
    m  = {64{1'b1}} >> (64 - w);
    sh = int'(b[5:0]) & (w - 1);
    p  = {64'd0, a} * {64'd0, b};
    sa = a[w-1] ? (a | ~m) : a;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a << sh;
      4'h3: r = $signed(sa) >>> sh;
      4'h4: r = a >> sh;
      4'h5: r = a & b;
      4'h6: r = a | b;
      4'h7: r = a ^ b;
      4'h8: r = p[63:0];
      4'h9: r = 64'(p >> w);
      4'hA: r = (b == 0) ? m : a / b;
      4'hB: r = (b == 0) ? a : a % b;
      default: r = 64'd0;
    endcase
    return r & m;
  endfunction

  // ---------------- XLEN=32 directed DUT ----------------
  logic        rst32, fl32, iv32, ir32, ov32, or32, by32;
  logic [3:0]  op32;
  logic [31:0] a32, b32, od32;
  logic [4:0]  tg32, ot32;
  exp_t        q32[$];

  alu_seq #(.XLEN(32)) dut32 (
    .clk(clk), .reset(rst32), .flush(fl32), .in_valid(iv32), .in_ready(ir32),
    .in_opt(op32), .in_a(a32), .in_b(b32), .in_tag(tg32), .out_valid(ov32),
    .out_ready(or32), .out_data(od32), .out_tag(ot32), .busy(by32)
  );

  initial begin : mon32
    bit   seen;
    bit   prev;
    exp_t e;
    seen = 0;
    prev = 0;
    forever begin
      @(negedge clk);
      if (rst32) begin
        seen = 0;
      end else if (ov32) begin
        if (q32.size() == 0) begin
          if (!prev) chk("dut32 unexpected out_valid", 1, 0);
        end else begin
          e = q32[0];
          if (!seen) begin
            chk("dut32 data", 64'(od32), e.data);
            chk("dut32 tag", 64'(ot32), 64'(e.tag));
            chk("dut32 latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            seen = 1;
          end
          if (or32) begin
            void'(q32.pop_front());
            seen = 0;
          end
        end
      end
      prev = ov32;
    end
  end

  task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp, input bit push);
    exp_t e;
    int   n;
    op32 = op; a32 = a; b32 = b; tg32 = tag; iv32 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ir32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir32) chk("dut32 accept timeout", 0, 1);
    if (push) begin
      e.data = 64'(exp); e.tag = tag; e.lat = lat_of(32, op, 64'(b)); e.acc = cyc + 1;
      q32.push_back(e);
    end
    @(posedge clk); #1;
    iv32 = 1'b0; a32 = $urandom; b32 = $urandom; op32 = 4'($urandom); tg32 = 5'($urandom);
  endtask

  task automatic drain32();
    int n;
    n = 0;
    while (q32.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("dut32 drain", 64'(q32.size()), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- XLEN=8 / XLEN=64 random sweeps ----------------
  logic rst_sw = 1'b1;

  for (genvar g = 0; g < 2; g++) begin : sweep
    localparam int W = (g == 0) ? 8 : 64;
    localparam logic [63:0] MASK = {64{1'b1}} >> (64 - W);
    logic         iv, ir, ov, ordy, by;
    logic [3:0]   op;
    logic [W-1:0] a, b, od;
    logic [4:0]   tg, ot;
    exp_t         q[$];
    bit           done = 0;

    alu_seq #(.XLEN(W)) dut (
      .clk(clk), .reset(rst_sw), .flush(1'b0), .in_valid(iv), .in_ready(ir),
      .in_opt(op), .in_a(a), .in_b(b), .in_tag(tg), .out_valid(ov),
      .out_ready(ordy), .out_data(od), .out_tag(ot), .busy(by)
    );

    initial begin : rdy
      forever begin
        ordy = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
    end

    initial begin : drv
      logic [63:0] ra, rb;
      logic [3:0]  rop;
      exp_t        e;
      int          n;
      iv = 1'b0; op = '0; a = '0; b = '0; tg = '0;
      wait (!rst_sw);
      @(posedge clk); #1;
      for (int i = 0; i < 1000; i++) begin
        rop = 4'($urandom_range(0, 15));
        ra  = {$urandom, $urandom};
        rb  = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 63);
        if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 63);
        if ($urandom_range(0, 7) == 0) rb = 64'd0;
        ra = ra & MASK;
        rb = rb & MASK;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        op = rop; a = ra[W-1:0]; b = rb[W-1:0]; tg = 5'($urandom); iv = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ir && n < 200) begin
          @(negedge clk);
          n++;
        end
        if (!ir) chk("sweep accept timeout", 0, 1);
        e.data = refm(W, rop, ra, rb); e.tag = tg; e.lat = lat_of(W, rop, rb); e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
        iv = 1'b0; a = W'({$urandom, $urandom}); b = W'({$urandom, $urandom});
      end
      n = 0;
      while (q.size() != 0 && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("sweep drain", 64'(q.size()), 0);
      done = 1;
    end

    initial begin : mon
      bit   seen;
      bit   prev;
      exp_t e;
      seen = 0;
      prev = 0;
      forever begin
        @(negedge clk);
        if (rst_sw) begin
          seen = 0;
        end else if (ov) begin
          if (q.size() == 0) begin
            if (!prev) chk("sweep unexpected out_valid", 1, 0);
          end else begin
            e = q[0];
            if (!seen) begin
              chk("sweep data", 64'(od), e.data);
              chk("sweep tag", 64'(ot), 64'(e.tag));
              chk("sweep latency", 64'(cyc - e.acc + 1), 64'(e.lat));
              seen = 1;
            end
            if (ordy) begin
              void'(q.pop_front());
              seen = 0;
            end
          end
        end
        prev = ov;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [31:0] hd;
    logic [4:0]  ht;
    bit          ok;
    int          n;
    rst32 = 1'b1; fl32 = 1'b0; iv32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; tg32 = '0;
    or32 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst32 = 1'b0; rst_sw = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 64'(ir32), 1);
    chk("reset busy", 64'(by32), 0);
    chk("reset out_valid", 64'(ov32), 0);
    chk("reset out_data", 64'(od32), 0);
    chk("reset out_tag", 64'(ot32), 0);
    @(posedge clk); #1;

    issue32(4'h0, 32'hFFFF_FFFF, 32'h1,        5'd1, 32'h0000_0000, 1);
    issue32(4'h1, 32'h0,         32'h1,        5'd2, 32'hFFFF_FFFF, 1);
    issue32(4'h3, 32'h8000_0000, 32'h24,       5'd3, 32'hF800_0000, 1);
    issue32(4'h4, 32'h8000_0000, 32'h24,       5'd4, 32'h0800_0000, 1);
    issue32(4'h2, 32'h1,         32'h21,       5'd5, 32'h0000_0002, 1);
    issue32(4'h5, 32'hF0F0,      32'hFF00,     5'd6, 32'h0000_F000, 1);
    issue32(4'h6, 32'hF0F0,      32'hFF00,     5'd7, 32'h0000_FFF0, 1);
    issue32(4'h7, 32'hF0F0,      32'hFF00,     5'd8, 32'h0000_0FF0, 1);
    issue32(4'hF, 32'h1234,      32'h5678,     5'd9, 32'h0000_0000, 1);

    issue32(4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'h0000_0001, 1);
    ok = 1; n = 0;
    @(negedge clk);
    while (!ov32 && n < 100) begin
      if (ir32 || !by32) ok = 0;
      @(negedge clk);
      n++;
    end
    chk("mul in_ready low while busy", 64'(ok), 1);
    chk("mul completes", 64'(ov32), 1);
    @(posedge clk); #1;

    issue32(4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE, 1);
    issue32(4'hA, 32'd100, 32'd7, 5'd12, 32'd14,         1);
    issue32(4'hB, 32'd100, 32'd7, 5'd13, 32'd2,          1);
    issue32(4'hA, 32'd5,   32'd0, 5'd14, 32'hFFFF_FFFF,  1);
    issue32(4'hB, 32'd5,   32'd0, 5'd15, 32'd5,          1);
    drain32();

    // backpressure
    or32 = 1'b0;
    issue32(4'h0, 32'd10, 32'd20, 5'd21, 32'd30, 1);
    n = 0;
    @(negedge clk);
    while (!ov32 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("backpressure result valid", 64'(ov32), 1);
    hd = od32; ht = ot32; ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (od32 !== hd || ot32 !== ht || ir32 || !ov32) ok = 0;
    end
    chk("backpressure hold stable", 64'(ok), 1);
    @(posedge clk); #1; or32 = 1'b1;
    @(posedge clk); #1; or32 = 1'b0;
    @(negedge clk);
    chk("after handshake in_ready", 64'(ir32), 1);
    chk("after handshake out_valid", 64'(ov32), 0);
    or32 = 1'b1;
    @(posedge clk); #1;

    // flush during divide, result dropped
    issue32(4'hA, 32'd1000, 32'd3, 5'd22, 32'd0, 0);
    repeat (9) @(posedge clk);
    #1; fl32 = 1'b1;
    @(posedge clk); #1; fl32 = 1'b0;
    @(negedge clk);
    chk("flush out_valid", 64'(ov32), 0);
    chk("flush in_ready", 64'(ir32), 1);
    chk("flush busy", 64'(by32), 0);
    ok = 1;
    repeat (40) begin
      @(negedge clk);
      if (ov32) ok = 0;
    end
    chk("no output after flush", 64'(ok), 1);
    @(posedge clk); #1;
    issue32(4'h0, 32'd2, 32'd3, 5'd23, 32'd5, 1);
    drain32();

    // asynchronous reset during multiply
    issue32(4'h8, 32'd3, 32'd5, 5'd24, 32'd0, 0);
    repeat (5) @(posedge clk);
    #2; rst32 = 1'b1;
    #1;
    chk("mid-op reset out_valid", 64'(ov32), 0);
    chk("mid-op reset out_data", 64'(od32), 0);
    chk("mid-op reset out_tag", 64'(ot32), 0);
    chk("mid-op reset in_ready", 64'(ir32), 1);
    chk("mid-op reset busy", 64'(by32), 0);
    @(posedge clk); #1; rst32 = 1'b0;
    ok = 1;
    repeat (40) begin
      @(negedge clk);
      if (ov32) ok = 0;
    end
    chk("no output after reset", 64'(ok), 1);

    n = 0;
    while (!(sweep[0].done && sweep[1].done) && n < 90000) begin
      @(posedge clk);
      n++;
    end
    chk("sweeps finished", 64'(sweep[0].done && sweep[1].done), 1);
    chk("dut32 queue empty", 64'(q32.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
